// File: rtl/security_pkg.sv
// security_pkg: default parameters and output flag ordering shared by the sensor front end.
package security_pkg;
    localparam int          DEF_DB_CYCLES    = 4;
    localparam int          DEF_DOOR_TIMEOUT = 16;
    localparam int          DEF_TL_CYCLES    = 32;
    localparam int          DEF_MAX_TRIES    = 3;
    localparam int          DEF_HOLD_CYCLES  = 8;
    localparam logic [15:0] DEF_CODE         = 16'h1234;
    // Flag vector order {p,f,d,pm,ptl,dtl,tl,pt,pp,rh}, MSB first.
    localparam int FLAG_W   = 10;
    localparam int FLAG_P   = 9;
    localparam int FLAG_F   = 8;
    localparam int FLAG_D   = 7;
    localparam int FLAG_PM  = 6;
    localparam int FLAG_PTL = 5;
    localparam int FLAG_DTL = 4;
    localparam int FLAG_TL  = 3;
    localparam int FLAG_PT  = 2;
    localparam int FLAG_PP  = 1;
    localparam int FLAG_RH  = 0;
endpackage

// File: rtl/debounce.sv
// debounce: 2-flop synchronizer followed by a stable-sample debouncer.
module debounce
    import security_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic s1, s2;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            out <= 1'b0;
        end else begin
            s1 <= in;
            s2 <= s1;
            if (s2 == out)
                cnt <= '0;
            else if (cnt == CW'(DB_CYCLES - 1)) begin
                out <= s2;
                cnt <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/sensor_frontend.sv
// sensor_frontend: debounced sensor levels, password checking, door/general/hold timers.
module sensor_frontend
    import security_pkg::*;
#(
    parameter int          DB_CYCLES    = DEF_DB_CYCLES,
    parameter int          DOOR_TIMEOUT = DEF_DOOR_TIMEOUT,
    parameter int          TL_CYCLES    = DEF_TL_CYCLES,
    parameter int          MAX_TRIES    = DEF_MAX_TRIES,
    parameter int          HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter logic [15:0] CODE         = DEF_CODE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        raw_pir,
    input  logic        raw_smoke,
    input  logic        raw_door,
    input  logic        raw_panic,
    input  logic        raw_rst_btn,
    input  logic [15:0] key_code,
    input  logic        key_enter,
    input  logic        timer_start,
    input  logic        clear_tries,
    output logic        p,
    output logic        f,
    output logic        d,
    output logic        pp,
    output logic        pm,
    output logic        ptl,
    output logic        dtl,
    output logic        tl,
    output logic        pt,
    output logic        rh
);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int DW = $clog2(DOOR_TIMEOUT + 1);
    localparam int GW = $clog2(TL_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic rb;
    logic [TW-1:0] tries, tries_inc;
    logic [DW-1:0] dcnt, dcnt_inc;
    logic [GW-1:0] tcnt;
    logic [HW-1:0] hcnt, hcnt_inc;

    debounce #(.DB_CYCLES(DB_CYCLES)) u_pir   (.clk(clk), .reset(reset), .in(raw_pir),     .out(p));
    debounce #(.DB_CYCLES(DB_CYCLES)) u_smoke (.clk(clk), .reset(reset), .in(raw_smoke),   .out(f));
    debounce #(.DB_CYCLES(DB_CYCLES)) u_door  (.clk(clk), .reset(reset), .in(raw_door),    .out(d));
    debounce #(.DB_CYCLES(DB_CYCLES)) u_panic (.clk(clk), .reset(reset), .in(raw_panic),   .out(pp));
    debounce #(.DB_CYCLES(DB_CYCLES)) u_btn   (.clk(clk), .reset(reset), .in(raw_rst_btn), .out(rb));

    // Saturating increments: counters never wrap.
    always_comb begin
        tries_inc = (tries == TW'(MAX_TRIES))    ? tries : tries + 1'b1;
        dcnt_inc  = (dcnt  == DW'(DOOR_TIMEOUT)) ? dcnt  : dcnt + 1'b1;
        hcnt_inc  = (hcnt  == HW'(HOLD_CYCLES))  ? hcnt  : hcnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tries <= '0;
            pm    <= 1'b0;
            ptl   <= 1'b0;
            pt    <= 1'b0;
            dcnt  <= '0;
            dtl   <= 1'b0;
            tcnt  <= '0;
            tl    <= 1'b0;
            hcnt  <= '0;
            rh    <= 1'b0;
        end else begin
            if (key_enter)
                pm <= (key_code == CODE);
            if (clear_tries) begin
                tries <= '0;
                ptl   <= 1'b0;
                pt    <= 1'b0;
            end else if (key_enter) begin
                pt    <= 1'b1;
                tries <= (key_code == CODE) ? '0 : tries_inc;
                ptl   <= (key_code != CODE) && (tries_inc >= TW'(MAX_TRIES));
            end
            dcnt <= d ? dcnt_inc : '0;
            dtl  <= d && (dcnt_inc == DW'(DOOR_TIMEOUT));
            // tcnt==0 with tl==0 is the idle state after reset; tl only sets on a 1->0 step.
            if (timer_start) begin
                tcnt <= GW'(TL_CYCLES);
                tl   <= 1'b0;
            end else if (tcnt != '0) begin
                tcnt <= tcnt - 1'b1;
                tl   <= (tcnt == GW'(1));
            end
            hcnt <= rb ? hcnt_inc : '0;
            rh   <= rb && (hcnt_inc == HW'(HOLD_CYCLES));
        end
    end
endmodule

// File: tb/tb_sensor_frontend.sv
// tb_sensor_frontend: directed checks of debounce, password, door, general and hold timers.
module tb_sensor_frontend;
    logic        clk = 1'b0;
    logic        reset;
    logic        raw_pir, raw_smoke, raw_door, raw_panic, raw_rst_btn;
    logic [15:0] key_code;
    logic        key_enter, timer_start, clear_tries;
    logic        p, f, d, pp, pm, ptl, dtl, tl, pt, rh;
    int          errors = 0;
    int          checks = 0;

    sensor_frontend dut (
        .clk(clk), .reset(reset),
        .raw_pir(raw_pir), .raw_smoke(raw_smoke), .raw_door(raw_door),
        .raw_panic(raw_panic), .raw_rst_btn(raw_rst_btn),
        .key_code(key_code), .key_enter(key_enter),
        .timer_start(timer_start), .clear_tries(clear_tries),
        .p(p), .f(f), .d(d), .pp(pp), .pm(pm), .ptl(ptl),
        .dtl(dtl), .tl(tl), .pt(pt), .rh(rh)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic enter(input logic [15:0] code, input logic clr);
        key_code    = code;
        key_enter   = 1'b1;
        clear_tries = clr;
        step(1);
        key_enter   = 1'b0;
        clear_tries = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hi, first;
        logic seen;
        reset = 1'b1;
        {raw_pir, raw_smoke, raw_door, raw_panic, raw_rst_btn} = '0;
        key_code = '0; key_enter = 0; timer_start = 0; clear_tries = 0;
        #12;
        check("reset_outputs", {p,f,d,pm,ptl,dtl,tl,pt,pp,rh}, 10'b0);
        step(1);
        reset = 1'b0;
        step(3);
        check("idle_outputs", {p,f,d,pm,ptl,dtl,tl,pt,pp,rh}, 10'b0);

        raw_door = 1'b1;
        step(5);  check("door_d_before", d, 1'b0);
        step(1);  check("door_d_rise", d, 1'b1);
        step(15); check("door_dtl_before", dtl, 1'b0);
        step(1);  check("door_dtl_rise", dtl, 1'b1);
        step(8);
        raw_door = 1'b0;
        step(5);  check("door_d_hold", {d, dtl}, 2'b11);
        step(1);  check("door_d_fall", {d, dtl}, 2'b01);
        step(1);  check("door_dtl_clear", dtl, 1'b0);

        raw_pir = 1'b1;
        step(3);
        raw_pir = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin step(1); seen |= p; end
        check("pir_glitch", seen, 1'b0);
        raw_pir = 1'b1;
        hi = 0; first = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (i == 10) raw_pir = 1'b0;
            if (p) begin hi++; if (first < 0) first = i; end
        end
        check("pir_first_high", first, 6);
        check("pir_high_len", hi, 10);

        enter(16'h0000, 1'b0); check("pw_fail1", {pm, pt, ptl}, 3'b010);
        enter(16'h0000, 1'b0); check("pw_fail2", {pm, pt, ptl}, 3'b010);
        enter(16'h0000, 1'b0); check("pw_fail3", {pm, pt, ptl}, 3'b011);
        enter(16'h0000, 1'b0); check("pw_fail4_sat", {pm, pt, ptl}, 3'b011);
        enter(16'h1234, 1'b0); check("pw_match", {pm, pt, ptl}, 3'b110);
        step(3);               check("pw_pm_hold", pm, 1'b1);
        enter(16'hBEEF, 1'b0);
        enter(16'hBEEF, 1'b0); check("pw_count2", {pm, pt, ptl}, 3'b010);
        enter(16'hBEEF, 1'b1); check("pw_clear_wins", {pm, pt, ptl}, 3'b000);
        enter(16'hBEEF, 1'b0);
        enter(16'hBEEF, 1'b0); check("pw_after_clear2", ptl, 1'b0);
        enter(16'hBEEF, 1'b0); check("pw_after_clear3", ptl, 1'b1);
        clear_tries = 1'b1; step(1); clear_tries = 1'b0;
        check("pw_clear_alone", {pm, pt, ptl}, 3'b000);

        check("tl_idle", tl, 1'b0);
        timer_start = 1'b1; step(1); timer_start = 1'b0;
        step(31); check("tl_before", tl, 1'b0);
        step(1);  check("tl_expire", tl, 1'b1);
        step(3);  check("tl_hold", tl, 1'b1);
        timer_start = 1'b1; step(1); timer_start = 1'b0;
        check("tl_cleared", tl, 1'b0);
        step(19);
        timer_start = 1'b1; step(1); timer_start = 1'b0;
        step(31); check("tl_reload_before", tl, 1'b0);
        step(1);  check("tl_reload_expire", tl, 1'b1);

        raw_rst_btn = 1'b1;
        step(13); check("rh_before", rh, 1'b0);
        step(1);  check("rh_rise", rh, 1'b1);
        step(2);  check("rh_hold", rh, 1'b1);
        #2 reset = 1'b1;
        #1 check("rh_async_reset", {p,f,d,pm,ptl,dtl,tl,pt,pp,rh}, 10'b0);
        raw_rst_btn = 1'b0;
        step(2);
        reset = 1'b0;
        step(10); check("post_reset_idle", {p,f,d,pm,ptl,dtl,tl,pt,pp,rh}, 10'b0);

        raw_smoke = 1'b1; raw_panic = 1'b1;
        step(6);  check("smoke_panic_rise", {f, pp}, 2'b11);
        raw_smoke = 1'b0; raw_panic = 1'b0;
        step(6);  check("smoke_panic_fall", {f, pp}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sensor_frontend.md
SENSOR_FRONTEND -- requirements
Module: sensor_frontend

Interface
- Parameters:
  - REQ-001 DB_CYCLES, 4, consecutive stable samples needed before a debounced input changes.
  - REQ-002 DOOR_TIMEOUT, 16, cycles the door stays open before dtl asserts.
  - REQ-003 TL_CYCLES, 32, length of the general timer in cycles.
  - REQ-004 MAX_TRIES, 3, failed password entries that assert ptl.
  - REQ-005 HOLD_CYCLES, 8, cycles the reset button is held before rh asserts.
  - REQ-006 CODE, 16'h1234, stored password.
- Ports:
  - REQ-007 clk  in  1  single system clock; all state on its rising edge.
  - REQ-008 reset  in  1  asynchronous, active-high reset.
  - REQ-009 raw_pir, raw_smoke, raw_door, raw_panic, raw_rst_btn  in  1 each  asynchronous raw sensor and button levels.
  - REQ-010 key_code  in  16  keypad code, valid only when key_enter is high.
  - REQ-011 key_enter  in  1  one-cycle code-submit strobe, synchronous to clk.
  - REQ-012 timer_start  in  1  synchronous pulse; (re)starts the general timer.
  - REQ-013 clear_tries  in  1  synchronous pulse; clears the try counter, ptl and pt.
  - REQ-014 p, f, d, pp  out  1 each  debounced presence, fire, door-open and panic levels.
  - REQ-015 pm  out  1  last submitted code matched CODE.
  - REQ-016 ptl  out  1  failed-try limit reached.
  - REQ-017 dtl  out  1  door open for DOOR_TIMEOUT cycles.
  - REQ-018 tl  out  1  general timer expired.
  - REQ-019 pt  out  1  a code has been submitted since the last clear_tries.
  - REQ-020 rh  out  1  reset button held for HOLD_CYCLES cycles.
  - All outputs are registered and consumed directly by the security controller FSM.

Function
- REQ-021 Each raw input passes through a 2-flop synchronizer and then a debouncer; the debounced output takes the synchronized value after DB_CYCLES consecutive equal samples. Any differing sample restarts the count.
- REQ-022 Latency from a stable raw edge to the debounced output edge is 2+DB_CYCLES cycles, with no glitch shorter than DB_CYCLES propagating.
- REQ-023 On key_enter, the block registers pm <= (key_code == CODE) and sets pt=1. pm holds until the next key_enter or reset.
- REQ-024 On key_enter with a mismatch, the try counter increments and saturates at MAX_TRIES. ptl=1 while count >= MAX_TRIES.
- REQ-025 On key_enter with a match, the try counter clears and ptl=0.
- REQ-026 If clear_tries and key_enter occur in the same cycle, clear_tries wins for the counter, ptl and pt, while pm still updates.
- REQ-027 Door timer:
  - counts while d=1 and saturates at DOOR_TIMEOUT;
  - dtl=1 while count == DOOR_TIMEOUT;
  - d=0 clears the count and dtl on the next edge.
- REQ-028 General timer:
  - timer_start loads TL_CYCLES, then the timer decrements each cycle;
  - tl=1 when it reaches 0 and holds there;
  - timer_start while running reloads and clears tl;
  - tl=0 after reset until the first expiry.
- REQ-029 The reset-button hold counter counts while the debounced button is 1 and saturates at HOLD_CYCLES. rh=1 at saturation; release clears the counter and rh.
- REQ-030 Counter widths are $clog2(max+1), and no counter wraps.

Reset
- REQ-031 Asynchronous assertion clears all synchronizers, debouncer states, counters and outputs to 0, with the general timer in its expired-idle state but tl=0.
- REQ-032 Reset asserted mid-count or mid-debounce abandons the operation. After release, behaviour matches power-up, and outputs change no earlier than the first clk edge.

Structure
- REQ-033 The default parameter values and the output flag bit order {p,f,d,pm,ptl,dtl,tl,pt,pp,rh} live in the shared package security_pkg.
- REQ-034 The synchronizer plus debouncer is one sub-module, debounce (ports clk, reset, in, out; parameter DB_CYCLES), instanced five times. The timers and password logic are inline.

Verification
- REQ-035 raw_door=1 held 30 cycles -> d rises at cycle 6 and dtl rises 16 cycles later; raw_door=0 -> d falls 6 cycles later and dtl clears the cycle after.
- REQ-036 raw_pir pulse of 3 cycles -> p stays 0; pulse of 10 cycles -> p high for 10 cycles, delayed by 6.
- REQ-037 key_code=16'h0000 with key_enter three times -> pm=0, pt=1, ptl=1 after the third; then 16'h1234 -> pm=1, ptl=0.
- REQ-038 timer_start then 32 cycles -> tl=1; timer_start at cycle 20 -> tl stays 0 until cycle 52.
- REQ-039 raw_rst_btn held 20 cycles -> rh=1 at cycle 14; assert reset at cycle 16 -> rh=0 immediately (asynchronous).
- REQ-040 clear_tries coincident with a failing key_enter at count 2 -> count 0, ptl=0, pt=0, pm=0.
